// File: rtl/screen_rom_sequencer_if.sv
// Bundle between the screen sequencer and its pixel source / image ROM bank.
// The slave side is the sequencer; the master side drives requests and ROM data.
interface screen_rom_sequencer_if #(
    parameter int NUM_SCREENS = 4,
    parameter int COLOR_W     = 3,
    parameter int ADDR_W      = 19,
    parameter int SEL_W       = 2
) ();

    logic [SEL_W-1:0]               mode_sel;
    logic                           mode_valid;
    logic                           frame_start;
    logic                           pix_req;
    logic [ADDR_W-1:0]              rom_addr;
    logic [NUM_SCREENS*COLOR_W-1:0] rom_q;
    logic [COLOR_W-1:0]             pix_data;
    logic                           pix_valid;
    logic [SEL_W-1:0]               cur_mode;
    logic                           mode_busy;

    modport master (
        output mode_sel,
        output mode_valid,
        output frame_start,
        output pix_req,
        output rom_q,
        input  rom_addr,
        input  pix_data,
        input  pix_valid,
        input  cur_mode,
        input  mode_busy
    );

    modport slave (
        input  mode_sel,
        input  mode_valid,
        input  frame_start,
        input  pix_req,
        input  rom_q,
        output rom_addr,
        output pix_data,
        output pix_valid,
        output cur_mode,
        output mode_busy
    );

endinterface

// File: rtl/screen_rom_sequencer.sv
// Shared-address image ROM sequencer with frame-aligned screen switching.
// Define SCREEN_BLANK_EN to insert one black frame after each applied switch.
module screen_rom_sequencer #(
    parameter int NUM_SCREENS   = 4,
    parameter int COLOR_W       = 3,
    parameter int ADDR_W        = 19,
    parameter int PIX_PER_FRAME = 307200,
    parameter int SEL_W         = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    screen_rom_sequencer_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIX_PER_FRAME - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

`ifdef SCREEN_BLANK_EN
    typedef enum logic [1:0] {
        SHOW,
        PENDING,
        BLANK
    } state_t;
`else
    typedef enum logic [1:0] {
        SHOW,
        PENDING
    } state_t;
`endif

    state_t             state;
    logic [SEL_W-1:0]   target;
    logic               pend;
    logic [SEL_W-1:0]   cur_mode;
    logic               mode_busy;
    logic [SEL_W-1:0]   req_mode;

    logic [ADDR_W-1:0]  addr_cnt;
    logic [ADDR_W-1:0]  rom_addr;
    logic               frame_end;
    logic               boundary;

    logic               v1;
    logic               v2;
    logic [SEL_W-1:0]   sel1;
    logic [SEL_W-1:0]   sel2;
    logic [COLOR_W-1:0] rom_pix;
    logic [COLOR_W-1:0] pix_data;
    logic               pix_valid;

`ifdef SCREEN_BLANK_EN
    logic               blank1;
    logic               blank2;
`endif

    // Out-of-range requests fall back to the start screen.
    assign req_mode = (int'(bus.mode_sel) < NUM_SCREENS) ? bus.mode_sel : '0;

    assign frame_end = bus.pix_req && (addr_cnt == LAST);
    assign boundary  = frame_end || bus.frame_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_cnt <= '0;
            rom_addr <= '0;
        end else if (bus.frame_start) begin
            if (bus.pix_req) begin
                rom_addr <= '0;
                addr_cnt <= ONE;
            end else begin
                addr_cnt <= '0;
            end
        end else if (bus.pix_req) begin
            rom_addr <= addr_cnt;
            addr_cnt <= frame_end ? '0 : addr_cnt + ONE;
        end
    end

    // A new request always overrides whatever the state logic did to pend/target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SHOW;
            target    <= '0;
            pend      <= 1'b0;
            cur_mode  <= '0;
            mode_busy <= 1'b0;
        end else begin
            unique case (state)
                SHOW: begin
                    if (pend) begin
                        if (target != cur_mode) begin
                            state     <= PENDING;
                            mode_busy <= 1'b1;
                        end else begin
                            pend <= 1'b0;
                        end
                    end
                end
                PENDING: begin
                    if (boundary) begin
                        cur_mode <= target;
                        pend     <= 1'b0;
`ifdef SCREEN_BLANK_EN
                        state    <= BLANK;
`else
                        state     <= SHOW;
                        mode_busy <= 1'b0;
`endif
                    end
                end
`ifdef SCREEN_BLANK_EN
                BLANK: begin
                    if (boundary) begin
                        if (pend && (target != cur_mode)) begin
                            state <= PENDING;
                        end else begin
                            state     <= SHOW;
                            mode_busy <= 1'b0;
                        end
                    end
                end
`endif
                default: begin
                    state     <= SHOW;
                    mode_busy <= 1'b0;
                end
            endcase
            if (bus.mode_valid) begin
                target <= req_mode;
                pend   <= 1'b1;
            end
        end
    end

    // Screen index travels with the address so the ROM output and select line up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            sel1      <= '0;
            sel2      <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            v1        <= bus.pix_req;
            v2        <= v1;
            sel1      <= cur_mode;
            sel2      <= sel1;
            pix_valid <= v2;
            pix_data  <= rom_pix;
        end
    end

`ifdef SCREEN_BLANK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank1 <= 1'b0;
            blank2 <= 1'b0;
        end else begin
            blank1 <= (state == BLANK);
            blank2 <= blank1;
        end
    end
`endif

    always_comb begin
        rom_pix = '0;
        for (int i = 0; i < NUM_SCREENS; i++) begin
            if (sel2 == SEL_W'(i)) begin
                rom_pix = bus.rom_q[i*COLOR_W +: COLOR_W];
            end
        end
`ifdef SCREEN_BLANK_EN
        if (blank2) begin
            rom_pix = '0;
        end
`endif
    end

    assign bus.rom_addr  = rom_addr;
    assign bus.pix_data  = pix_data;
    assign bus.pix_valid = pix_valid;
    assign bus.cur_mode  = cur_mode;
    assign bus.mode_busy = mode_busy;

endmodule
